atcaxi2tluh500_onehot2bin_pipe: RTL and testbench

- Registered one-hot to binary encoder with valid/ready handshake; the inverse of the bridge's bin2onehot decode.
- Converts one-hot select vectors (grant, source-slot and ID masks) back to binary indices for TileLink source/AXI ID fields.
- Carries a payload alongside, flags non-one-hot inputs, and sustains full throughput through a 2-entry skid stage.

---
 rtl/atcaxi2tluh500_onehot2bin_pipe_pkg.sv | 19 +
 rtl/atcaxi2tluh500_onehot2bin.sv | 29 ++
 rtl/atcaxi2tluh500_onehot2bin_pipe.sv | 150 +++++++++++++++
 tb/tb_atcaxi2tluh500_onehot2bin_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/atcaxi2tluh500_onehot2bin_pipe_pkg.sv
// Shared definitions for the one-hot to binary encoder pipeline: output width helper,
// error counter geometry and the pipeline occupancy encoding.
package atcaxi2tluh500_onehot2bin_pipe_pkg;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // A single-bit vector still needs a one-bit index field.
    function automatic int bin_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/atcaxi2tluh500_onehot2bin.sv
// Combinational LSB-priority N-to-W encoder with a one-hot check.
// The check exists only when ATCAXI2TLUH500_ONEHOT_CHK_EN is defined; otherwise err is 0.
module atcaxi2tluh500_onehot2bin
    import atcaxi2tluh500_onehot2bin_pipe_pkg::*;
#(
    parameter int N = 8,
    parameter int W = bin_width(N)
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] bin,
    output logic         err
);

    always_comb begin
        // NOTE: assign a default before any conditional update so no latch is inferred.
        bin = '0;
        // Scanning from the top down lets the lowest set bit win.
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot[i]) bin = W'(i);
        end
    end

`ifdef ATCAXI2TLUH500_ONEHOT_CHK_EN
    assign err = ($countones(onehot) != 1);
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/atcaxi2tluh500_onehot2bin_pipe.sv
// Registered one-hot to binary encoder with a 2-entry skid stage and valid/ready handshakes.
// Error reporting is built only when ATCAXI2TLUH500_ONEHOT_CHK_EN is defined.
module atcaxi2tluh500_onehot2bin_pipe
    import atcaxi2tluh500_onehot2bin_pipe_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 8,
    localparam int W = bin_width(N)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_onehot,
    input  logic [DW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_bin,
    output logic [DW-1:0]        out_data,
    output logic                 out_err,
    input  logic                 clr_err,
    output logic                 sticky_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    pipe_state_e   state, state_nxt;
    logic [W-1:0]  enc_bin, m_bin, s_bin;
    logic [DW-1:0] m_data, s_data;
    logic          enc_err;
    logic          accept, xfer;
    logic          load_m_in, load_m_skid, load_s;

    atcaxi2tluh500_onehot2bin #(.N(N), .W(W)) u_enc (
        .onehot (in_onehot),
        .bin    (enc_bin),
        .err    (enc_err)
    );

    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign out_bin   = m_bin;
    assign out_data  = m_data;

    always_comb begin
        state_nxt   = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
            ST_EMPTY: if (accept) begin
                load_m_in = 1'b1;
                state_nxt = ST_ONE;
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    load_s    = 1'b1;
                    state_nxt = ST_TWO;
                end else if (xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: if (xfer) begin
                load_m_skid = 1'b1;
                state_nxt   = ST_ONE;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // in_ready is registered from the next occupancy so it never depends on out_ready.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!aresetn) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_bin  <= '0;
            m_data <= '0;
        end else if (load_m_in) begin
            m_bin  <= enc_bin;
            m_data <= in_data;
        end else if (load_m_skid) begin
            m_bin  <= s_bin;
            m_data <= s_data;
        end
    end

    // NOTE: the skid entry is only read after being loaded, so it carries no reset.
    always_ff @(posedge aclk) begin
        if (load_s) begin
            s_bin  <= enc_bin;
            s_data <= in_data;
        end
    end

`ifdef ATCAXI2TLUH500_ONEHOT_CHK_EN
    logic m_err, s_err;
    logic acc_err;

    assign acc_err = accept & enc_err;
    assign out_err = m_err;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_err <= 1'b0;
        end else if (load_m_in) begin
            m_err <= enc_err;
        end else if (load_m_skid) begin
            m_err <= s_err;
        end
    end

    always_ff @(posedge aclk) begin
        if (load_s) s_err <= enc_err;
    end

    // Clear wins over a same-cycle error, which then restarts the count at one.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sticky_err <= 1'b0;
            err_cnt    <= '0;
        end else if (clr_err) begin
            sticky_err <= acc_err;
            err_cnt    <= acc_err ? ERR_CNT_W'(1) : '0;
        end else if (acc_err) begin
            sticky_err <= 1'b1;
            err_cnt    <= (err_cnt == ERR_CNT_MAX) ? err_cnt : err_cnt + 1'b1;
        end
    end
`else
    logic unused_chk;

    // Without the check there is nothing to clear and no error to carry.
    assign unused_chk = clr_err ^ enc_err;
    assign out_err    = 1'b0;
    assign sticky_err = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_atcaxi2tluh500_onehot2bin_pipe.sv
// Self-checking bench: directed scenarios plus a random phase against a queue-based model.
// Error expectations follow ATCAXI2TLUH500_ONEHOT_CHK_EN as compiled.
module tb_atcaxi2tluh500_onehot2bin_pipe;

`ifdef ATCAXI2TLUH500_ONEHOT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_onehot;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_bin;
    logic [7:0] out_data;
    logic       out_err;
    logic       clr_err;
    logic       sticky_err;
    logic [7:0] err_cnt;

    atcaxi2tluh500_onehot2bin_pipe #(.N(8), .DW(8)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_onehot  (in_onehot),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bin    (out_bin),
        .out_data   (out_data),
        .out_err    (out_err),
        .clr_err    (clr_err),
        .sticky_err (sticky_err),
        .err_cnt    (err_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int         bin;
        logic [7:0] data;
        bit         err;
    } beat_t;

    beat_t q[$];
    bit    m_rdy    = 1'b0;
    int    m_cnt    = 0;
    bit    m_sticky = 1'b0;
    int    total    = 0;
    int    bad      = 0;

    // Index of the lowest set bit, isolated with v & -v.
    function automatic int lsb_idx(input logic [7:0] v);
        logic [7:0] iso;
        iso = v & (~v + 8'd1);
        return (v == 8'd0) ? 0 : $clog2(int'(iso));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(m_rdy));
        if (q.size() > 0) begin
            check({tag, ".out_bin"}, 32'(out_bin), 32'(q[0].bin));
            check({tag, ".out_data"}, 32'(out_data), 32'(q[0].data));
            check({tag, ".out_err"}, 32'(out_err), 32'(q[0].err));
        end
        check({tag, ".sticky_err"}, 32'(sticky_err), 32'(m_sticky));
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
    endtask

    // Capture inputs, let one edge pass, advance the model, then settle.
    task automatic cycle();
        logic       rst, v, r, c;
        logic [7:0] oh, d;
        bit         acc, xf, aerr;
        beat_t      b;
        rst = aresetn; v = in_valid; r = out_ready; c = clr_err; oh = in_onehot; d = in_data;
        @(posedge aclk);
        if (!rst) begin
            q.delete();
            m_rdy = 1'b0; m_cnt = 0; m_sticky = 1'b0;
        end else begin
            acc  = v && m_rdy;
            xf   = (q.size() > 0) && r;
            aerr = CHK && acc && ($countones(oh) != 1);
            if (xf) void'(q.pop_front());
            if (acc) begin
                b.bin = lsb_idx(oh); b.data = d; b.err = CHK && ($countones(oh) != 1);
                q.push_back(b);
            end
            m_rdy = (q.size() < 2);
            if (CHK && c) begin
                m_cnt = aerr ? 1 : 0;
                m_sticky = aerr;
            end else if (aerr) begin
                if (m_cnt < 255) m_cnt++;
                m_sticky = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] oh, input logic [7:0] d,
                         input logic r, input logic c);
        in_valid = v; in_onehot = oh; in_data = d; out_ready = r; clr_err = c;
    endtask

    initial begin
        aresetn = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #1;

        // Reset and idle
        for (int i = 0; i < 3; i++) cycle();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.out_bin", 32'(out_bin), 32'd0);
        check("rst.out_data", 32'(out_data), 32'd0);
        check("rst.out_err", 32'(out_err), 32'd0);
        check_all("rst");
        aresetn = 1'b1;
        cycle();
        check("rel.in_ready", 32'(in_ready), 32'd1);
        check_all("rel");

        // Streaming
        drive(1'b1, 8'h40, 8'hA5, 1'b1, 1'b0);
        cycle();
        check("stream.out_bin", 32'(out_bin), 32'd6);
        check_all("stream");
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(1 << i), 8'(8'h10 + i), 1'b1, 1'b0);
            cycle();
            check_all($sformatf("b2b%0d", i));
        end
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        cycle();
        check_all("b2b.tail");
        check("b2b.last_bin", 32'(out_bin), 32'd7);

        // Backpressure
        drive(1'b1, 8'h02, 8'h21, 1'b0, 1'b0);
        cycle();
        check_all("bp.first");
        drive(1'b1, 8'h08, 8'h83, 1'b0, 1'b0);
        cycle();
        check("bp.in_ready_low", 32'(in_ready), 32'd0);
        check_all("bp.second");
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_all($sformatf("bp.drain%0d", i));
        end

        // Error detection
        drive(1'b1, 8'h00, 8'h55, 1'b1, 1'b0);
        cycle();
        check("err.zero_bin", 32'(out_bin), 32'd0);
        check_all("err.zero");
        drive(1'b1, 8'h0C, 8'h66, 1'b1, 1'b0);
        cycle();
        check("err.multi_bin", 32'(out_bin), 32'd2);
        check_all("err.multi");
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        cycle();
        check("err.cnt2", 32'(err_cnt), CHK ? 32'd2 : 32'd0);
        check_all("err.idle");

        // Saturation and clear
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 8'hFF, 8'(i), 1'b1, 1'b0);
            cycle();
            check_all($sformatf("sat%0d", i));
        end
        check("sat.cnt", 32'(err_cnt), CHK ? 32'd255 : 32'd0);
        drive(1'b1, 8'h03, 8'h77, 1'b1, 1'b1);
        cycle();
        check("clr.with_err", 32'(err_cnt), CHK ? 32'd1 : 32'd0);
        check_all("clr.with_err");
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        cycle();
        check_all("clr.alone");

        // Random traffic with upstream holding stalled beats
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_onehot = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
                in_data   = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clr_err   = ($urandom_range(0, 40) == 0);
            cycle();
            check_all($sformatf("rnd%0d", i));
        end

        // Reset mid-flight from the two-entry state
        drive(1'b1, 8'h10, 8'hC1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h20, 8'hC2, 1'b0, 1'b0);
        cycle();
        check("mid.two_full", 32'(in_ready), 32'd0);
        check_all("mid.two");
        aresetn = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        cycle();
        check("mid.rst_valid", 32'(out_valid), 32'd0);
        check_all("mid.rst");
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("mid.no_emit", 32'(out_valid), 32'd0);
            check_all($sformatf("mid.after%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
